// File: rtl/key_debounce.sv
// Synchronising debouncer and press/release edge detector for one active-low pushbutton.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to add auto-repeat PRESS_PULSE strobes while the key is held.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic KEY_N,
    output logic KEY_LEVEL,
    output logic PRESS_PULSE,
    output logic RELEASE_PULSE
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CYC = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
`else
    localparam int unsigned MAX_CYC = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the counters cannot honour.
    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
            $error("key_debounce: illegal timing parameters");
        end
    endgenerate

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             key_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_level_q, key_level_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RDEL_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rep_phase_q, rep_phase_d;
`endif

    always_comb begin
        sync1_d         = KEY_N;
        sync2_d         = sync1_q;
        key_s           = ~sync2_q;
        state_d         = state_q;
        cnt_d           = cnt_q;
        key_level_d     = key_level_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        rcnt_d          = rcnt_q;
        rep_phase_d     = rep_phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = HELD;
                    key_level_d   = 1'b1;
                    press_pulse_d = 1'b1;
                    cnt_d         = '0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                    rcnt_d        = '0;
                    rep_phase_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                    // First repeat waits the long delay, later ones the short period.
                    if (!rep_phase_q && rcnt_q == RDEL_LAST) begin
                        press_pulse_d = 1'b1;
                        rcnt_d        = '0;
                        rep_phase_d   = 1'b1;
                    end else if (rep_phase_q && rcnt_q == RPER_LAST) begin
                        press_pulse_d = 1'b1;
                        rcnt_d        = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                    rcnt_d      = '0;
                    rep_phase_d = 1'b0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = IDLE;
                    key_level_d     = 1'b0;
                    release_pulse_d = 1'b1;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            state_q         <= IDLE;
            cnt_q           <= '0;
            key_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rcnt_q          <= '0;
            rep_phase_q     <= 1'b0;
`endif
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            key_level_q     <= key_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rcnt_q          <= rcnt_d;
            rep_phase_q     <= rep_phase_d;
`endif
        end
    end

    assign KEY_LEVEL     = key_level_q;
    assign PRESS_PULSE   = press_pulse_q;
    assign RELEASE_PULSE = release_pulse_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random bouncing,
// compared every cycle against a window-based behavioural model of the debouncer.
module tb_key_debounce;

    localparam int DEB  = 4;
    localparam int RDEL = 10;
    localparam int RPER = 5;

    logic clock = 1'b0;
    logic reset;
    logic key_n;
    logic key_level;
    logic press_pulse;
    logic release_pulse;

    always #5 clock = ~clock;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RDEL),
        .REPEAT_PERIOD(RPER)
    ) dut (
        .CLOCK_50(clock),
        .RESET(reset),
        .KEY_N(key_n),
        .KEY_LEVEL(key_level),
        .PRESS_PULSE(press_pulse),
        .RELEASE_PULSE(release_pulse)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int press_seen = 0;

    bit model_valid = 1'b0;
    bit m_level;
    bit m_press;
    bit m_release;
    bit sync_pipe[$];
    bit hist[$];
    bit ks;
    bit stable;
    int streak;
    int n_held;

    // Model: a level flips once the last DEB synchronised samples all disagree with it;
    // repeats fire at fixed offsets into an unbroken run of pressed samples.
    always @(posedge clock) begin
        edge_cnt++;
        if (reset) begin
            sync_pipe   = '{1'b0, 1'b0};
            hist.delete();
            m_level     = 1'b0;
            m_press     = 1'b0;
            m_release   = 1'b0;
            streak      = 0;
            model_valid = 1'b1;
        end else begin
            ks = sync_pipe.pop_front();
            sync_pipe.push_back(!key_n);
            hist.push_back(ks);
            if (hist.size() > DEB) void'(hist.pop_front());
            m_press   = 1'b0;
            m_release = 1'b0;
            stable = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] == m_level) stable = 1'b0;
            if (stable) begin
                m_level = !m_level;
                if (m_level) m_press = 1'b1;
                else         m_release = 1'b1;
            end
            if (m_level && ks) streak++;
            else               streak = 0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            n_held = streak - 1;
            if (n_held == RDEL || (n_held > RDEL && (n_held - RDEL) % RPER == 0))
                m_press = 1'b1;
`endif
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        if (model_valid) begin
            checks++;
            if (key_level !== m_level || press_pulse !== m_press || release_pulse !== m_release) begin
                errors++;
                $display("[TB] FAIL model_cmp edge %0d: got level=%b press=%b release=%b, want level=%b press=%b release=%b",
                         edge_cnt, key_level, press_pulse, release_pulse, m_level, m_press, m_release);
            end
        end
        if (press_pulse === 1'b1) press_seen++;
    end

    task automatic applyStimulus(input bit k, input int n);
        key_n = k;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input bit lvl, input bit prs, input bit rel);
        checks++;
        if (key_level !== lvl || press_pulse !== prs || release_pulse !== rel) begin
            errors++;
            $display("[TB] FAIL %s: got level=%b press=%b release=%b, want level=%b press=%b release=%b",
                     name, key_level, press_pulse, release_pulse, lvl, prs, rel);
        end
        checks++;
        if (m_level != lvl || m_press != prs || m_release != rel) begin
            errors++;
            $display("[TB] FAIL %s_model: got level=%b press=%b release=%b, want level=%b press=%b release=%b",
                     name, m_level, m_press, m_release, lvl, prs, rel);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d press strobes, want %0d", name, got, want);
        end
    endtask

    int  p0;
    int  exp_rep;
    bit  k;
    int  len;

    initial begin
        reset = 1'b1;
        key_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_state", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b1, 3);

        $display("[TB] clean press");
        applyStimulus(1'b0, 5);
        checkOutput("press_pre", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1);
        checkOutput("press_edge", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1);
        checkOutput("press_after", 1'b1, 1'b0, 1'b0);

        $display("[TB] release glitch");
        p0 = press_seen;
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 8);
        checkOutput("glitch", 1'b1, 1'b0, 1'b0);
        checkCount("glitch_no_press", press_seen - p0, 0);

        $display("[TB] release");
        applyStimulus(1'b1, 5);
        checkOutput("rel_pre", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1);
        checkOutput("rel_edge", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1);
        checkOutput("rel_after", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3);

        $display("[TB] bouncing press");
        p0 = press_seen;
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 5);
        checkOutput("bounce_pre", 1'b0, 1'b0, 1'b0);
        checkCount("bounce_no_press", press_seen - p0, 0);
        applyStimulus(1'b0, 1);
        checkOutput("bounce_edge", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1);
        checkOutput("bounce_after", 1'b1, 1'b0, 1'b0);

        $display("[TB] long hold");
        p0 = press_seen;
        applyStimulus(1'b0, 39);
        @(negedge clock);
        #1;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        exp_rep = 7;
`else
        exp_rep = 0;
`endif
        checkCount("hold_repeats", press_seen - p0, exp_rep);
        applyStimulus(1'b1, 10);

        $display("[TB] reset mid press");
        applyStimulus(1'b0, 3);
        reset = 1'b1;
        applyStimulus(1'b0, 1);
        reset = 1'b0;
        checkOutput("rst_edge", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2);
        checkOutput("rst_no_strobe", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3);
        checkOutput("rst_pre", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1);
        checkOutput("rst_press", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 10);

        $display("[TB] random bouncing");
        for (int i = 0; i < 300; i++) begin
            k   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            if ($urandom_range(0, 19) == 0) len = int'($urandom_range(20, 50));
            reset = ($urandom_range(0, 39) == 0);
            applyStimulus(k, 1);
            reset = 1'b0;
            applyStimulus(k, len - 1);
        end
        applyStimulus(1'b1, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
